led_activity_stretch: RTL and testbench

- Board-level LED driver sitting directly downstream of the FPGA top's activity sources (UART TX/RX lines, heartbeat blink, core status bits).
- Turns short, asynchronous activity transitions into visible, fixed-length LED pulses.
- Enforces a minimum dark gap between pulses so continuous traffic reads as flicker, not a solid-on LED.
- Drives the `led` bus in place of direct wiring; optional global PWM dimming.

---
 rtl/led_activity_stretch.sv | 141 ++++++++++++++
 tb/tb_led_activity_stretch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/led_activity_stretch.sv
// Activity-to-LED pulse stretcher: per-channel synchroniser, edge detector and IDLE/ON/GAP
// pulse FSM with registered LED drive. Define LED_ACTIVITY_PWM_EN to add global PWM dimming.
module led_activity_stretch #(
  parameter int N_CH    = 8,
  parameter int CLK_HZ  = 50000000,
  parameter int HOLD_MS = 50,
  parameter int GAP_MS  = 20,
  parameter int W_PWM   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  act_in,
  input  logic [W_PWM-1:0] bright,
  output logic [N_CH-1:0]  led,
  output logic             busy
);

  localparam int HOLD_CYC = CLK_HZ / 1000 * HOLD_MS;
  localparam int GAP_CYC  = CLK_HZ / 1000 * GAP_MS;
  localparam int MAX_CYC  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CW       = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  logic [N_CH-1:0] on_vec;
  logic [N_CH-1:0] live_vec;
  logic [N_CH-1:0] led_next;
  logic            pwm_gate;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    // sync_reg[0] = s1, sync_reg[1] = s2, sync_reg[2] = history s3
    logic [2:0]    sync_reg;
    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          pend_reg, pend_next;
    logic          ev;

    assign ev = sync_reg[1] ^ sync_reg[2];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_reg  <= '0;
        state_reg <= IDLE;
        cnt_reg   <= '0;
        pend_reg  <= 1'b0;
      end else begin
        sync_reg  <= {sync_reg[1:0], act_in[gi]};
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        pend_reg  <= pend_next;
      end
    end

    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pend_next  = pend_reg;
      case (state_reg)
        IDLE: begin
          if (ev) begin
            state_next = ON;
            cnt_next   = HOLD_LD;
          end
        end
        ON: begin
          if (ev) begin
            cnt_next = HOLD_LD;
          end else if (cnt_reg == '0) begin
            if (GAP_CYC > 0) begin
              state_next = GAP;
              cnt_next   = GAP_LD;
              pend_next  = 1'b0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            cnt_next = cnt_reg - CW'(1);
          end
        end
        GAP: begin
          if (ev) pend_next = 1'b1;
          // An event landing on the terminal count still earns a pulse.
          if (cnt_reg == '0) begin
            pend_next = 1'b0;
            if (pend_reg || ev) begin
              state_next = ON;
              cnt_next   = HOLD_LD;
            end else begin
              state_next = IDLE;
            end
          end else begin
            cnt_next = cnt_reg - CW'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          pend_next  = 1'b0;
        end
      endcase
    end

    assign on_vec[gi]   = (state_reg == ON);
    assign live_vec[gi] = (state_reg != IDLE);
  end

`ifdef LED_ACTIVITY_PWM_EN
  logic [W_PWM-1:0] pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + W_PWM'(1);
  end

  // Full-scale brightness must be solid on, not 15/16 duty.
  assign pwm_gate = (bright == '1) || (pwm_cnt < bright);
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign pwm_gate      = 1'b1;
`endif

  assign led_next = on_vec & {N_CH{pwm_gate}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led  <= '0;
      busy <= 1'b0;
    end else begin
      led  <= led_next;
      busy <= |live_vec;
    end
  end

endmodule

// File: tb/tb_led_activity_stretch.sv
// Bench for led_activity_stretch: interval-based reference model checked every cycle plus
// hand-computed directed checks. Two instances: gap enabled (a) and gap disabled (b).
module tb_led_activity_stretch;
  localparam int HOLD = 10;
  localparam int GAPC = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] act_a = 2'b00;
  logic [1:0] act_b = 2'b00;
  logic [3:0] bright = 4'hF;
  logic [1:0] led_a, led_b;
  logic       busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_activity_stretch #(.N_CH(2), .CLK_HZ(1000), .HOLD_MS(HOLD), .GAP_MS(GAPC), .W_PWM(4)) dut_a (
    .clk(clk), .rst(rst), .act_in(act_a), .bright(bright), .led(led_a), .busy(busy_a));

  led_activity_stretch #(.N_CH(2), .CLK_HZ(1000), .HOLD_MS(HOLD), .GAP_MS(0), .W_PWM(4)) dut_b (
    .clk(clk), .rst(rst), .act_in(act_b), .bright(bright), .led(led_b), .busy(busy_b));

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: each channel is described by the edge index where its ON window ends
  // and where its dark gap ends; events extend or queue these windows.
  int  on_end[4], gap_end[4];
  bit  pend[4];
  bit  h1[4], h2[4], h3[4];
  int  n, pwm_m;
  logic [1:0] exp_led_a = '0, exp_led_b = '0;
  logic exp_busy_a = 1'b0, exp_busy_b = 1'b0;

  always @(posedge clk) begin
    bit on[4];
    bit live[4];
    bit gate, ev, a, in_on, in_gap;
    int gap;
    if (rst) begin
      n = 0;
      pwm_m = 0;
      for (int m = 0; m < 4; m++) begin
        on_end[m] = 0; gap_end[m] = 0; pend[m] = 0;
        h1[m] = 0; h2[m] = 0; h3[m] = 0;
      end
      exp_led_a = '0; exp_led_b = '0; exp_busy_a = 0; exp_busy_b = 0;
    end else begin
      n++;
`ifdef LED_ACTIVITY_PWM_EN
      gate = (bright == 4'hF) || (pwm_m < int'(bright));
`else
      gate = 1'b1;
`endif
      pwm_m = (pwm_m + 1) % 16;
      for (int m = 0; m < 4; m++) begin
        gap    = (m < 2) ? GAPC : 0;
        a      = (m < 2) ? act_a[m] : act_b[m-2];
        ev     = h2[m] ^ h3[m];
        in_on  = (n - 1) < on_end[m];
        in_gap = !in_on && ((n - 1) < gap_end[m]);
        on[m]   = in_on;
        live[m] = in_on || in_gap;
        if (!in_gap && ev) begin
          on_end[m] = n + HOLD; gap_end[m] = n + HOLD + gap; pend[m] = 0;
        end else if (in_gap) begin
          if (ev) pend[m] = 1;
          if (n == gap_end[m] && pend[m]) begin
            on_end[m] = n + HOLD; gap_end[m] = n + HOLD + gap; pend[m] = 0;
          end
        end
        h3[m] = h2[m]; h2[m] = h1[m]; h1[m] = a;
      end
      exp_led_a  = {on[1] & gate, on[0] & gate};
      exp_led_b  = {on[3] & gate, on[2] & gate};
      exp_busy_a = live[0] | live[1];
      exp_busy_b = live[2] | live[3];
    end
  end

  always @(negedge clk) begin
    chk("model_led_a",  8'(led_a),  rst ? 8'h0 : 8'(exp_led_a));
    chk("model_busy_a", 8'(busy_a), rst ? 8'h0 : 8'(exp_busy_a));
    chk("model_led_b",  8'(led_b),  rst ? 8'h0 : 8'(exp_led_b));
    chk("model_busy_b", 8'(busy_b), rst ? 8'h0 : 8'(exp_busy_b));
  end

  task automatic step(input int c);
    repeat (c) @(negedge clk);
  endtask

`ifdef LED_ACTIVITY_PWM_EN
  int tcnt = 0;
  int bl[3] = '{4, 15, 0};
  int bw[3] = '{4, 16, 0};
  task automatic pstep();
    step(1);
    tcnt++;
    if (tcnt % 5 == 0) act_a[1] = ~act_a[1];
  endtask
`endif

  initial begin
    step(2);
    chk("reset_led", 8'(led_a), 8'h0);
    chk("reset_busy", 8'(busy_a), 8'h0);
    rst = 1'b0;
    step(5);

    // Single event: led high after edges k+3..k+12, busy through k+17.
    act_a[0] = 1'b1;
    step(3);  chk("single_lat_lo", 8'(led_a[0]), 8'h0);
    step(1);  chk("single_lat_hi", 8'(led_a[0]), 8'h1);
    step(9);  chk("single_last_hi", 8'(led_a[0]), 8'h1);
              chk("single_other_ch", 8'(led_a[1]), 8'h0);
    step(1);  chk("single_off", 8'(led_a[0]), 8'h0);
    step(4);  chk("single_busy_gap", 8'(busy_a), 8'h1);
    step(1);  chk("single_busy_end", 8'(busy_a), 8'h0);
    step(20);

    // Retrigger in ON: second event six cycles after the first restarts the hold.
    act_a[0] = ~act_a[0];
    step(6);
    act_a[0] = ~act_a[0];
    step(12); chk("retrig_hi", 8'(led_a[0]), 8'h1);
    step(1);  chk("retrig_last_hi", 8'(led_a[0]), 8'h1);
    step(1);  chk("retrig_off", 8'(led_a[0]), 8'h0);
    step(4);  chk("retrig_busy_gap", 8'(busy_a), 8'h1);
    step(1);  chk("retrig_busy_end", 8'(busy_a), 8'h0);
    step(20);

    // Event at gap cycle 2: full gap then a fresh pulse.
    act_a[0] = ~act_a[0];
    step(11);
    act_a[0] = ~act_a[0];
    step(7);  chk("gapev_dark", 8'(led_a[0]), 8'h0);
    step(1);  chk("gapev_on", 8'(led_a[0]), 8'h1);
    step(9);  chk("gapev_last_hi", 8'(led_a[0]), 8'h1);
    step(1);  chk("gapev_off", 8'(led_a[0]), 8'h0);
    step(30);

    // Event on the gap terminal count: no extra gap cycle.
    act_a[0] = ~act_a[0];
    step(15);
    act_a[0] = ~act_a[0];
    step(3);  chk("gapterm_dark", 8'(led_a[0]), 8'h0);
    step(1);  chk("gapterm_on", 8'(led_a[0]), 8'h1);
    step(9);  chk("gapterm_last_hi", 8'(led_a[0]), 8'h1);
    step(1);  chk("gapterm_off", 8'(led_a[0]), 8'h0);
    step(30);

    // No-gap instance: continuous toggling keeps the LED solid.
    for (int i = 0; i < 8; i++) begin
      act_b[0] = ~act_b[0];
      for (int j = 0; j < 4; j++) begin
        step(1);
        if (i >= 1) chk("nogap_solid", 8'(led_b[0]), 8'h1);
      end
    end
    step(9);  chk("nogap_last_hi", 8'(led_b[0]), 8'h1);
    step(1);  chk("nogap_off", 8'(led_b[0]), 8'h0);
    step(20);

    // Reset mid-pulse, then release with act_in held high.
    act_a[0] = 1'b0;
    step(30);
    act_a[0] = 1'b1;
    step(6);  chk("rstmid_pre", 8'(led_a[0]), 8'h1);
    #2 rst = 1'b1;
    #1 chk("rstmid_led_async", 8'(led_a), 8'h0);
       chk("rstmid_busy_async", 8'(busy_a), 8'h0);
    step(2);
    #2 rst = 1'b0;
    step(3);  chk("rel_lat_lo", 8'(led_a[0]), 8'h0);
    step(1);  chk("rel_lat_hi", 8'(led_a[0]), 8'h1);
    step(9);  chk("rel_last_hi", 8'(led_a[0]), 8'h1);
    step(1);  chk("rel_off", 8'(led_a[0]), 8'h0);
    step(20); chk("rel_single_pulse", 8'(led_a[0]), 8'h0);
              chk("rel_busy_end", 8'(busy_a), 8'h0);

`ifdef LED_ACTIVITY_PWM_EN
    // Channel 1 held in ON by retriggering every 5 cycles; count lit cycles per 16.
    act_a[1] = ~act_a[1];
    repeat (4) pstep();
    for (int p = 0; p < 3; p++) begin
      int hi;
      bright = 4'(bl[p]);
      pstep();
      pstep();
      hi = 0;
      for (int c = 0; c < 16; c++) begin
        pstep();
        hi += int'(led_a[1]);
      end
      chk("pwm_duty", 8'(hi), 8'(bw[p]));
    end
    chk("pwm_dark_busy", 8'(busy_a), 8'h1);
    bright = 4'hF;
    step(30);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
